// File: rtl/fullchip_mc.sv
// fullchip_mc: multi-core attention top with a registered, per-core masked
// issue stage and a snapshot collector that streams core outputs over
// valid/ready in ascending core order.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   mem_in, inst        operand word and instruction shared by all cores
//   in_valid, core_mask issue qualifier and per-core issue enable
//   capture             pulse: snapshot every core out (ignored while busy)
//   out_valid/out_ready readout handshake
//   out_core_id, out    index and data of the presented snapshot
//   busy                undelivered snapshots remain
//   capture_drop        sticky: a capture arrived while busy

// Behavioural core model: registers every lane to the zero-extended low
// operand byte whenever a non-NOP instruction arrives, holds otherwise.
module core #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int pr      = 8,
    parameter int inst_w  = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [pr*bw-1:0]        mem_in,
    input  logic [inst_w-1:0]       inst,
    output logic [bw_psum*col-1:0]  out
);
    logic [bw_psum*col-1:0] out_q, out_d;
    logic                   unused_hi;

    assign unused_hi = ^mem_in[pr*bw-1:bw];

    always_comb begin
        out_d = out_q;
        if (inst != '0) begin
            for (int k = 0; k < col; k++) begin
                out_d[k*bw_psum +: bw_psum] =
                    {{(bw_psum-bw){1'b0}}, mem_in[bw-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign out = out_q;
endmodule

module fullchip_mc #(
    parameter int col      = 8,
    parameter int bw       = 8,
    parameter int bw_psum  = 2*bw+4,
    parameter int pr       = 8,
    parameter int num_core = 2,
    parameter int inst_w   = 19,
    parameter int cid_w    = (num_core > 1) ? $clog2(num_core) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [pr*bw-1:0]        mem_in,
    input  logic [inst_w-1:0]       inst,
    input  logic                    in_valid,
    input  logic [num_core-1:0]     core_mask,
    input  logic                    capture,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [cid_w-1:0]        out_core_id,
    output logic [bw_psum*col-1:0]  out,
    output logic                    busy,
    output logic                    capture_drop
);
    localparam int OW = bw_psum*col;
    localparam int PW = pr*bw;

    typedef enum logic {IDLE, SEND} state_t;

    logic [PW-1:0]       issue_mem_q  [num_core];
    logic [PW-1:0]       issue_mem_d  [num_core];
    logic [inst_w-1:0]   issue_inst_q [num_core];
    logic [inst_w-1:0]   issue_inst_d [num_core];
    logic [OW-1:0]       core_out     [num_core];
    logic [OW-1:0]       snap_q       [num_core];
    logic [OW-1:0]       snap_d       [num_core];
    logic [num_core-1:0] pending_q, pending_d, pend_clr;
    logic                drop_q, drop_d;
    state_t              state_q, state_d;
    logic [cid_w-1:0]    cur_id;
    logic                xfer;

    always_comb begin
        for (int i = 0; i < num_core; i++) begin
            if (in_valid && core_mask[i]) begin
                issue_mem_d[i]  = mem_in;
                issue_inst_d[i] = inst;
            end else begin
                issue_mem_d[i]  = '0;
                issue_inst_d[i] = '0;
            end
        end
    end

    for (genvar g = 0; g < num_core; g++) begin : g_core
        core #(
            .col(col), .bw(bw), .bw_psum(bw_psum),
            .pr(pr), .inst_w(inst_w)
        ) u_core (
            .clk   (clk),
            .reset (reset),
            .mem_in(issue_mem_q[g]),
            .inst  (issue_inst_q[g]),
            .out   (core_out[g])
        );
    end

    // Lowest-index pending core is the one presented.
    always_comb begin
        cur_id = '0;
        for (int i = num_core-1; i >= 0; i--) begin
            if (pending_q[i]) cur_id = cid_w'(i);
        end
    end

    assign busy      = |pending_q;
    assign out_valid = (state_q == SEND);
    assign xfer      = out_valid && out_ready;

    always_comb begin
        pend_clr         = pending_q;
        pend_clr[cur_id] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        snap_d    = snap_q;
        // A capture is only taken with nothing outstanding, so the final
        // transfer edge still drops it.
        if (capture && busy) drop_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (capture && !busy) begin
                    snap_d    = core_out;
                    pending_d = core_mask;
                    if (core_mask != '0) state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    pending_d = pend_clr;
                    if (pend_clr == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < num_core; i++) begin
                issue_mem_q[i]  <= '0;
                issue_inst_q[i] <= '0;
                snap_q[i]       <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            for (int i = 0; i < num_core; i++) begin
                issue_mem_q[i]  <= issue_mem_d[i];
                issue_inst_q[i] <= issue_inst_d[i];
                snap_q[i]       <= snap_d[i];
            end
        end
    end

    assign out_core_id  = out_valid ? cur_id : '0;
    assign out          = out_valid ? snap_q[cur_id] : '0;
    assign capture_drop = drop_q;
endmodule

// File: tb/tb_fullchip_mc.sv
// tb_fullchip_mc: table-driven issue checks plus hand sequences for
// capture/readout, with a scoreboard queue of expected snapshots.
module tb_fullchip_mc;
    localparam int OW = 160;
    localparam int PW = 64;
    localparam int NC = 2;

    logic          clk, reset;
    logic [PW-1:0] mem_in;
    logic [18:0]   inst;
    logic          in_valid;
    logic [1:0]    core_mask;
    logic          capture;
    logic          out_valid, out_ready;
    logic [0:0]    out_core_id;
    logic [OW-1:0] out;
    logic          busy, capture_drop;

    fullchip_mc u_dut (
        .clk(clk), .reset(reset), .mem_in(mem_in), .inst(inst),
        .in_valid(in_valid), .core_mask(core_mask), .capture(capture),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_core_id(out_core_id), .out(out), .busy(busy),
        .capture_drop(capture_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [0:0]    id;
        logic [OW-1:0] d;
    } exp_t;

    typedef struct {
        logic          v;
        logic [1:0]    m;
        logic [PW-1:0] mem;
        logic [18:0]   ins;
        logic [PW-1:0] em0, em1;
        logic [18:0]   ei0, ei1;
    } vec_t;

    exp_t     sb[$];
    logic [7:0] model [NC];
    int       checks = 0;
    int       failures = 0;

    function automatic logic [OW-1:0] lanes(input logic [7:0] b);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*20 +: 20] = {12'b0, b};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("sb_id", out_core_id, e.id);
                chk("sb_data", out, e.d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] m, input logic [7:0] b);
        in_valid  = 1'b1;
        core_mask = m;
        inst      = 19'd1;
        mem_in    = {$urandom, $urandom_range(0, 16777215), b};
        step();
        in_valid  = 1'b0;
        core_mask = '0;
        inst      = '0;
        mem_in    = '0;
        for (int i = 0; i < NC; i++) if (m[i]) model[i] = b;
    endtask

    task automatic cap(input logic [1:0] m, input logic acc);
        exp_t e;
        capture   = 1'b1;
        core_mask = m;
        if (acc) begin
            for (int i = 0; i < NC; i++) begin
                if (m[i]) begin
                    e.id = 1'(i);
                    e.d  = lanes(model[i]);
                    sb.push_back(e);
                end
            end
        end
        step();
        capture   = 1'b0;
        core_mask = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        for (int i = 0; i < NC; i++) model[i] = '0;
    endtask

    vec_t vt [5];
    logic [7:0] prev [NC];

    initial begin
        reset = 1'b1; mem_in = '0; inst = '0; in_valid = 1'b0;
        core_mask = '0; capture = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NC; i++) model[i] = '0;

        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            mem_in    = {$urandom, $urandom};
            inst      = 19'($urandom);
            in_valid  = 1'($urandom);
            core_mask = 2'($urandom);
            capture   = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out, '0);
        chk("rst_core_id", out_core_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", capture_drop, 1'b0);
        for (int i = 0; i < NC; i++) begin
            chk("rst_pin_mem", u_dut.issue_mem_q[i], '0);
            chk("rst_pin_inst", u_dut.issue_inst_q[i], '0);
            chk("rst_core_out", u_dut.core_out[i], '0);
        end
        reset = 1'b0; mem_in = '0; inst = '0; in_valid = 1'b0;
        core_mask = '0; capture = 1'b0; out_ready = 1'b0;

        // Issue table
        vt[0] = '{1'b1, 2'b10, 64'h1122334455667705, 19'd1,
                  64'h0, 64'h1122334455667705, 19'd0, 19'd1};
        vt[1] = '{1'b1, 2'b01, 64'hAABBCCDD00112203, 19'd1,
                  64'hAABBCCDD00112203, 64'h0, 19'd1, 19'd0};
        vt[2] = '{1'b0, 2'b11, 64'hFFFFFFFFFFFFFFA5, 19'd2,
                  64'h0, 64'h0, 19'd0, 19'd0};
        vt[3] = '{1'b1, 2'b11, 64'h0000000000000011, 19'h7FFFF,
                  64'h11, 64'h11, 19'h7FFFF, 19'h7FFFF};
        vt[4] = '{1'b1, 2'b00, 64'h0000000000000099, 19'd3,
                  64'h0, 64'h0, 19'd0, 19'd0};
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NC; i++) prev[i] = model[i];
            in_valid  = vt[k].v;
            core_mask = vt[k].m;
            mem_in    = vt[k].mem;
            inst      = vt[k].ins;
            for (int i = 0; i < NC; i++)
                if (vt[k].v && vt[k].m[i] && vt[k].ins != 0)
                    model[i] = vt[k].mem[7:0];
            step();
            chk("tbl_pin_mem0", u_dut.issue_mem_q[0], vt[k].em0);
            chk("tbl_pin_mem1", u_dut.issue_mem_q[1], vt[k].em1);
            chk("tbl_pin_inst0", u_dut.issue_inst_q[0], vt[k].ei0);
            chk("tbl_pin_inst1", u_dut.issue_inst_q[1], vt[k].ei1);
            chk("tbl_core_out0", u_dut.core_out[0], lanes(prev[0]));
            chk("tbl_core_out1", u_dut.core_out[1], lanes(prev[1]));
        end
        in_valid = 1'b0; core_mask = '0; mem_in = '0; inst = '0;
        step();
        chk("tbl_settle0", u_dut.core_out[0], lanes(model[0]));
        chk("tbl_settle1", u_dut.core_out[1], lanes(model[1]));

        // Serialized readout
        issue(2'b01, 8'h03);
        issue(2'b10, 8'h07);
        step();
        out_ready = 1'b1;
        cap(2'b11, 1'b1);
        chk("ser_valid", out_valid, 1'b1);
        chk("ser_busy", busy, 1'b1);
        step();
        step();
        chk("ser_valid_end", out_valid, 1'b0);
        chk("ser_busy_end", busy, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        cap(2'b11, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_id", out_core_id, 1'b0);
            chk("bp_data", out, lanes(8'h03));
            step();
        end
        out_ready = 1'b1;
        step();
        step();
        chk("bp_valid_end", out_valid, 1'b0);
        chk("bp_sb_empty", 32'(sb.size()), 0);

        // Capture while busy is dropped
        out_ready = 1'b0;
        cap(2'b11, 1'b1);
        issue(2'b01, 8'h09);
        step();
        chk("drop_core0_new", u_dut.core_out[0], lanes(8'h09));
        cap(2'b11, 1'b0);
        chk("drop_flag", capture_drop, 1'b1);
        chk("drop_snap_kept", out, lanes(8'h03));
        out_ready = 1'b1;
        step();
        step();
        chk("drop_valid_end", out_valid, 1'b0);
        chk("drop_sticky", capture_drop, 1'b1);

        // Capture on the final-accept edge
        do_reset();
        chk("rst_clears_drop", capture_drop, 1'b0);
        issue(2'b10, 8'h07);
        step();
        out_ready = 1'b1;
        cap(2'b10, 1'b1);
        chk("fa_id", out_core_id, 1'b1);
        cap(2'b11, 1'b0);
        chk("fa_drop", capture_drop, 1'b1);
        chk("fa_valid", out_valid, 1'b0);
        chk("fa_busy", busy, 1'b0);

        // Zero-mask capture
        do_reset();
        cap(2'b00, 1'b1);
        chk("m0_valid", out_valid, 1'b0);
        chk("m0_busy", busy, 1'b0);
        chk("m0_drop", capture_drop, 1'b0);

        // Mid-readout reset
        issue(2'b01, 8'h03);
        issue(2'b10, 8'h07);
        step();
        out_ready = 1'b0;
        cap(2'b11, 1'b1);
        chk("mr_valid", out_valid, 1'b1);
        do_reset();
        chk("mr_valid_after", out_valid, 1'b0);
        chk("mr_busy_after", busy, 1'b0);
        chk("mr_out_after", out, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("mr_no_send", out_valid, 1'b0);
            step();
        end

        chk("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fullchip_mc.md
# fullchip_mc

Multi-core top-level for the attention accelerator: instantiates `num_core` copies of `core` behind a registered input stage with per-core issue masking. It adds an output collector that snapshots every core's `out` on request and returns the snapshots one core at a time over a valid/ready handshake. It replaces the single-core top as the chip boundary; the core interface is unchanged.

## Interface
- `col`, 8: PE columns per core.
- `bw`, 8: operand width.
- `bw_psum`, 2*bw+4: psum lane width.
- `pr`, 8: operand lanes per `mem_in` word.
- `num_core`, 2: core instances (1..8).
- `inst_w`, 19: core instruction width.
- `cid_w`, max(1, clog2(num_core)): core-id width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `mem_in` in pr*bw: operand word for the cores.
- `inst` in inst_w: core instruction.
- `in_valid` in 1: `mem_in`/`inst` valid this cycle.
- `core_mask` in num_core: bit i set = core i receives this issue.
- `capture` in 1: pulse; snapshot all core outputs.
- `out_valid` out 1: `out` holds a snapshot.
- `out_ready` in 1: consumer accepts `out`.
- `out_core_id` out cid_w: core index of the current `out`.
- `out` out bw_psum*col: snapshot data.
- `busy` out 1: collector has undelivered snapshots.
- `capture_drop` out 1: sticky; a capture was ignored.

## Operation
- Issue stage: one register per core for `mem_in` and `inst`. On an edge with `in_valid`=1 and `core_mask[i]`=1, core i's registers load `mem_in`/`inst`. Otherwise they load zero, and `inst`=0 is the core NOP.
- All cores share `mem_in`; masking is the only per-core difference.
- Collector holds `num_core` snapshot registers (bw_psum*col each) and a `pending[num_core-1:0]` vector.
- On an edge with `capture`=1 and `busy`=0, all snapshot registers load the current core `out` values, and `pending` loads `core_mask`.
- `capture` with `busy`=1 is ignored: snapshots and `pending` are unchanged and `capture_drop` sets. `capture_drop` clears only on reset.
- FSM states:
  - IDLE: `out_valid`=0. On capture with nonzero mask, go to SEND.
  - SEND: present the lowest-index pending core. On `out_valid`&&`out_ready`, clear that pending bit and advance to the next lowest pending bit. After the last one is accepted, return to IDLE.
- A capture with `core_mask`=0 captures nothing and stays in IDLE.
- `busy` = |pending.
- While `out_valid`=1 and `out_ready`=0, `out` and `out_core_id` hold stable.
- `out_valid` never drops without a transfer.
- Accepted snapshots are not re-sent. Ascending core-index order is guaranteed.

## Timing
- Reset values: all issue registers 0, snapshots 0, `pending` 0, FSM IDLE, `out_valid` 0, `out` 0, `out_core_id` 0, `busy` 0, `capture_drop` 0.
- Reset mid-SEND abandons remaining snapshots; outputs are at reset values on the next cycle.
- Issue latency: inputs sampled at edge t are on core pins after edge t (one register). There is no backpressure on issue.
- Capture latency: `capture` at edge t gives `out_valid`=1 and `busy`=1 after edge t. The first snapshot is the core `out` value present before edge t.
- Throughput: one snapshot per cycle with `out_ready` held high. N pending cores take N cycles. `busy` falls after the edge accepting the last snapshot.
- Capture on the same edge as the final transfer: `busy` is still 1, so the capture is dropped and `capture_drop` sets.
- Issue and capture are independent; both may occur on the same edge.

## Test plan
Benches use a core stub with the same ports. The stub registers `out` <= each of the `col` lanes = zero-extended `mem_in[bw-1:0]` when `inst`!=0; it holds otherwise.

- Reset: hold `reset` 3 cycles with random inputs, then release. Every output and every core pin is 0; `busy`=0.
- Masked issue: `num_core`=2, `mem_in` low byte=0x05, `inst`=1, `core_mask`=2'b10, `in_valid`=1 for one edge. After the edge, core1 pins = (0x05, 1) and core0 pins = (0, 0). Two edges later, core1 `out` lanes=5 and core0 `out`=0.
- Serialized readout: issue 0x03 to core0, then 0x07 to core1. Then `capture` with mask 2'b11 and `out_ready`=1. Next two cycles: (`out_core_id`=0, lanes 3), then (`out_core_id`=1, lanes 7). `out_valid` and `busy` are 0 in the third cycle.
- Backpressure: same setup with `out_ready`=0 for 4 cycles. Core0 data holds unchanged with `out_valid`=1, and is delivered exactly once on the first ready cycle.
- Drop and same-edge events: `capture` while `busy`=1 leaves the snapshots intact and `capture_drop`=1 until reset. `capture` on the final-accept edge is also dropped. `capture` with mask 0 leaves `out_valid`=0 and `busy`=0.
- Mid-readout reset: assert `reset` while core0's snapshot is valid and not accepted. The next cycle has `out_valid`=0 and `pending`=0, and core1's snapshot is never delivered.
